// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the legal operand-width range.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// The team's one-bit full adder: S/C1 from inputs A, B and carry-in C0.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic C0,
    output logic C1,
    output logic S
);

    assign S  = A ^ B ^ C0;
    assign C1 = (A & B) | (C0 & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder processes one bit pair per clock, LSB first,
// with a start/busy/done handshake around a WIDTH-cycle add.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    generate
        if (!width_legal(WIDTH)) begin : g_width_check
            $error("serial_adder_ctrl: WIDTH out of range 2..32");
        end
    endgenerate

    state_t           state_reg;
    state_t           state_next;
    logic [CW-1:0]    count_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] s_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    logic fa_s;
    logic fa_c1;
    logic accept;
    logic last_bit;

    full_adder u_full_adder (
        .A  (a_sh_reg[0]),
        .B  (b_sh_reg[0]),
        .C0 (carry_reg),
        .C1 (fa_c1),
        .S  (fa_s)
    );

    // A new add is only taken when no operation is in flight.
    assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_bit = (state_reg == RUN) && (count_reg == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_bit ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            carry_reg <= 1'b0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            s_sh_reg  <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            count_reg <= '0;
        end else if (state_reg == RUN) begin
            carry_reg <= fa_c1;
            s_sh_reg  <= {fa_s, s_sh_reg[WIDTH-1:1]};
            a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
            b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
            // Wrap to zero on the last bit so the counter never holds WIDTH.
            if (last_bit) begin
                count_reg <= '0;
                sum_reg   <= {fa_s, s_sh_reg[WIDTH-1:1]};
                cout_reg  <= fa_c1;
            end else begin
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder stage that feeds the team's existing full_adder one bit pair per clock, LSB first. It registers the carry between cycles and assembles the WIDTH-bit sum. It uses a start/busy/done handshake, so a WIDTH-bit add costs one full_adder plus a small FSM. It sits between an operand source (register file or test stimulus) and any consumer of a completed sum.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a new add; sampled on rising clk edge
a  input  WIDTH  operand A; sampled only on the accepting edge
b  input  WIDTH  operand B; sampled only on the accepting edge
cin  input  1  carry-in; sampled only on the accepting edge
busy  output  1  high while an add is in progress
done  output  1  one-cycle pulse: sum/cout valid and new
sum  output  WIDTH  result of the last completed add
cout  output  1  carry-out of the last completed add

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry reg=0, shift regs=0. Release is synchronous to clk; the first accepting edge is the first rising edge with rst=0.
- FSM states:
  - IDLE: waiting.
  - RUN: one bit processed per cycle.
  - DONE: exactly one cycle.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --(counter==WIDTH-1 at edge)--> DONE.
  - DONE --start--> RUN (back-to-back add).
  - DONE --!start--> IDLE.
- Accepting edge (start=1 in IDLE or DONE): load a_sh<=a, b_sh<=b, carry<=cin, counter<=0, state<=RUN.
- RUN, every edge:
  - full_adder inputs: A=a_sh[0], B=b_sh[0], C0=carry.
  - carry<=C1.
  - s_sh<={S, s_sh[WIDTH-1:1]}.
  - a_sh, b_sh shift right by 1.
  - counter increments.
- Final RUN edge (counter==WIDTH-1): sum<={S, s_sh[WIDTH-1:1]}, cout<=C1, state<=DONE.
- sum/cout change only on that final edge. They hold all other times, including through a following RUN.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state, so there is no combinational path from start.
- Latency: start sampled at edge E0. The bit processing edges are E1..E_WIDTH. done is high in the cycle after E_WIDTH, for exactly one cycle. Throughput is one add per WIDTH+1 cycles with start held or re-asserted in DONE.
- start while busy: ignored. Operands are not re-sampled and the counter is unaffected.
- a/b/cin changing during RUN: no effect.
- rst asserted mid-RUN: the operation is aborted immediately and all registers return to reset values. No done pulse is produced for the aborted op.
- Arithmetic: {cout,sum} == a + b + cin modulo 2^(WIDTH+1), unsigned. Wrap-around on overflow is required behaviour (e.g. 0xFF+0x01 gives 0x00 with cout=1).
- Counter width: clog2(WIDTH). It never reaches WIDTH.

Decomposition:
- Shared package/include holds:
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2. Encoding 2'd3 is unreachable and recovers to IDLE.
  - The WIDTH legal-range limits.
- Single sub-module: the existing full_adder (ports A, B, C0, C1, S), instantiated once. It holds no local copy of the adder logic.
- The FSM, counter and shift registers live in serial_adder_ctrl itself.

Test Plan:
1. WIDTH=8, a=0x25, b=0x1A, cin=0, 1-cycle start -> busy high 8 cycles; done pulse one cycle later; sum=0x3F, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (wrap).
3. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
4. Start a=0x10, b=0x20. At RUN cycle 3, pulse start with a=0x77 and change a/b -> result 0x30, cout=0. Second start ignored: exactly one done pulse.
5. Start a=0x55, b=0xAA; assert rst at RUN cycle 4 -> busy/done/sum/cout go 0 asynchronously; no done afterwards. Then 0x01+0x01 -> 0x02.
6. Hold start high across two adds (0x03+0x04, then 0x80+0x80) -> done pulses 9 cycles apart; sum=0x07/cout=0, then sum=0x00/cout=1. sum stays 0x07 throughout the second RUN.
